mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback formatter for the MIPS core.
- Captures ALU result and raw load word from the memory stage, then sign/zero-extends sub-word loads.
- Drives the register file write port (regWrite, writeReg, writeData) one cycle after capture.
- Also provides forwarding data, misaligned-load fault reporting and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage accepts; combinational, equals !stall && !reset.
- in_reg_write  in  1  instruction writes a register.
- in_mem_to_reg  in  1  1 selects formatted load data, 0 selects ALU result.
- in_load_type  in  3  load kind, see package enum.
- in_alu_result  in  DATA_W  ALU result / load effective address.
- in_mem_data  in  DATA_W  raw aligned word from data memory.
- in_dest  in  REG_AW  destination register.
- stall  in  1  hazard unit hold.
- flush  in  1  kill held entry.
- regWrite  out  1  register file write enable.
- writeReg  out  REG_AW  register file write address.
- writeData  out  DATA_W  register file write data.
- fwd_valid  out  1  forwarding data valid.
- fwd_reg  out  REG_AW  forwarding register.
- fwd_data  out  DATA_W  forwarding data.
- load_fault  out  1  one-cycle pulse on misaligned load.
- fault_addr  out  DATA_W  address of last faulting load; sticky.
- retire_count  out  32  retired instructions.

Behaviour:
- Reset (sync, highest priority): all outputs 0, entry valid cleared, first-cycle flag cleared; in_ready=0 while reset.
- Capture: on posedge with in_valid && in_ready, latch all in_* fields; entry becomes valid. Latency 1: outputs reflect the entry in the following cycle.
- Stall: entry and all registers hold; no capture.
- Flush: entry invalid next cycle. Priority: reset > flush > stall > capture. Flush with in_valid high discards the incoming instruction too.
- Empty cycle (no capture, no stall): entry becomes invalid.
- Load encoding: LW=0, LH=1, LHU=2, LB=3, LBU=4; 5-7 = NONE, which uses in_alu_result.
- Byte lanes are big-endian, offset = alu_result[1:0]:
  - Byte offset 0 = bits [31:24].
  - Halfword offset 0 = [31:16], offset 2 = [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned: LW with offset≠0, or LH/LHU with offset[0]=1, when in_mem_to_reg=1.
  - load_fault pulses on the entry's first cycle.
  - fault_addr loads alu_result.
  - Write suppressed.
- regWrite is asserted only on the first valid cycle of an entry; a stalled held entry does not rewrite. Requires entry valid, reg_write=1, dest≠0 and no fault. The register file does not protect $zero, so this stage must.
- writeReg/writeData track the held entry whenever it is valid; they hold their last values when the entry is invalid.
- Forwarding: fwd_valid = the same condition as the write, but true for every cycle the entry is held, including stalls. fwd_reg = dest; fwd_data = writeData.
- retire_count increments once per entry on its first valid cycle; faulting and flushed-after-capture entries included; wraps 0xFFFFFFFF→0.
- Flush during an entry's first cycle: that cycle's write and count still occur; invalidation takes effect next cycle.

Decomposition:
- Package mips_pkg:
  - load_type_e enum.
  - REG_ZERO constant = 5'd0.
  - DATA_W, REG_AW constants.
- Submodule load_formatter: combinational lane select + extend + misalign detect; inputs load_type, offset, mem_data; outputs data, misaligned.

Test Plan:
- ALU op: dest=8, alu=0x12345678, mem_to_reg=0 → next cycle regWrite=1, writeReg=8, writeData=0x12345678, retire_count=1.
- LB at addr 0x1001, mem=0x11F02233 → writeData=0xFFFFFFF0. LBU at the same address → 0x000000F0. LHU at addr 0x1002, mem=0x1122ABCD → 0x0000ABCD.
- LW at addr 0x2002:
  - load_fault pulses 1 cycle.
  - fault_addr=0x00002002.
  - regWrite=0, fwd_valid=0.
  - retire_count increments.
- Write to dest=0 with alu=0xDEADBEEF → regWrite=0, fwd_valid=0.
- Stall for 3 cycles after capture (dest=9):
  - regWrite high only in the first cycle.
  - fwd_valid high all 4 cycles.
  - in_ready=0 during the stall.
  - retire_count increments by 1.
- Other control cases:
  - Flush with in_valid high → no capture, entry invalid.
  - Reset asserted mid-stall → all outputs 0 next cycle.
  - retire_count preset to 0xFFFFFFFF then one retire → 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and the load-kind encoding for the MIPS memory/writeback path.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  // Encodings 5..7 all mean "not a load"; the stage forwards the ALU result.
  typedef enum logic [2:0] {
    LT_LW   = 3'd0,
    LT_LH   = 3'd1,
    LT_LHU  = 3'd2,
    LT_LB   = 3'd3,
    LT_LBU  = 3'd4,
    LT_NONE = 3'd5
  } load_type_e;

endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// Big-endian byte/halfword lane select with sign/zero extension and
// misalignment detection for raw aligned load words.
module load_formatter
  import mips_pkg::*;
(
  input  logic [2:0]        load_type,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] data,
  output logic              misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to the load kind.
  always_comb begin
    byte_sel   = 8'h00;
    half_sel   = offset[1] ? mem_data[15:0] : mem_data[31:16];
    data       = mem_data;
    misaligned = 1'b0;
    case (offset)
      2'd0:    byte_sel = mem_data[31:24];
      2'd1:    byte_sel = mem_data[23:16];
      2'd2:    byte_sel = mem_data[15:8];
      default: byte_sel = mem_data[7:0];
    endcase
    case (load_type)
      LT_LW: begin
        data       = mem_data;
        misaligned = (offset != 2'd0);
      end
      LT_LH: begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      LT_LHU: begin
        data       = {16'h0000, half_sel};
        misaligned = offset[0];
      end
      LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data = {24'h000000, byte_sel};
      default: data = mem_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures one instruction, formats load data,
// drives the register-file write port, forwarding, fault and retire count.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [2:0]        in_load_type,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              stall,
  input  logic              flush,
  output logic              regWrite,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              load_fault,
  output logic [DATA_W-1:0] fault_addr,
  output logic [31:0]       retire_count
);

  logic              valid_q, valid_d;
  logic              first_q, first_d;
  logic              wr_ok_q, wr_ok_d;
  logic              fault_q, fault_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] fault_addr_q, fault_addr_d;
  logic [31:0]       retire_count_q, retire_count_d;

  logic [DATA_W-1:0] fmt_data;
  logic              fmt_misaligned;
  logic              is_load;
  logic              capture;
  logic              misaligned;

  load_formatter u_fmt (
    .load_type  (in_load_type),
    .offset     (in_alu_result[1:0]),
    .mem_data   (in_mem_data),
    .data       (fmt_data),
    .misaligned (fmt_misaligned)
  );

  assign in_ready   = !stall && !reset;
  assign is_load    = in_mem_to_reg && (in_load_type <= LT_LBU);
  assign misaligned = in_mem_to_reg && fmt_misaligned;
  assign capture    = in_valid && in_ready && !flush;

  // Next-state: flush beats stall beats capture. The result is formatted at
  // capture time so the held entry already carries its final write data.
  // Retirement is counted at capture, which lands it in the entry's first cycle.
  always_comb begin
    valid_d        = 1'b0;
    first_d        = 1'b0;
    wr_ok_d        = wr_ok_q;
    fault_d        = fault_q;
    dest_d         = dest_q;
    data_d         = data_q;
    fault_addr_d   = fault_addr_q;
    retire_count_d = retire_count_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (capture) begin
      valid_d        = 1'b1;
      first_d        = 1'b1;
      dest_d         = in_dest;
      data_d         = is_load ? fmt_data : in_alu_result;
      fault_d        = misaligned;
      // $zero is not protected by the register file, so guard it here.
      wr_ok_d        = in_reg_write && (in_dest != REG_AW'(REG_ZERO)) && !misaligned;
      retire_count_d = retire_count_q + 32'd1;
      if (misaligned) fault_addr_d = in_alu_result;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q        <= 1'b0;
      first_q        <= 1'b0;
      wr_ok_q        <= 1'b0;
      fault_q        <= 1'b0;
      dest_q         <= '0;
      data_q         <= '0;
      fault_addr_q   <= '0;
      retire_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      first_q        <= first_d;
      wr_ok_q        <= wr_ok_d;
      fault_q        <= fault_d;
      dest_q         <= dest_d;
      data_q         <= data_d;
      fault_addr_q   <= fault_addr_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign regWrite     = valid_q && first_q && wr_ok_q;
  assign writeReg     = dest_q;
  assign writeData    = data_q;
  assign fwd_valid    = valid_q && wr_ok_q;
  assign fwd_reg      = dest_q;
  assign fwd_data     = data_q;
  assign load_fault   = valid_q && first_q && fault_q;
  assign fault_addr   = fault_addr_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases then random traffic
// against a behavioural model of the writeback rules.
module tb_mem_wb_stage;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_ready, in_reg_write, in_mem_to_reg;
  logic [2:0]  in_load_type;
  logic [31:0] in_alu_result, in_mem_data;
  logic [4:0]  in_dest;
  logic        stall, flush;
  logic        regWrite, fwd_valid, load_fault;
  logic [4:0]  writeReg, fwd_reg;
  logic [31:0] writeData, fwd_data, fault_addr, retire_count;

  int total = 0;
  int bad   = 0;

  // Model of the held entry.
  logic        m_valid = 1'b0, m_first = 1'b0, m_wr = 1'b0, m_fault = 1'b0;
  logic [4:0]  m_dest = '0;
  logic [31:0] m_data = '0, m_faddr = '0, m_retire = '0;

  always #5 clock = ~clock;

  mem_wb_stage dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_load_type  (in_load_type),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
    .in_dest       (in_dest),
    .stall         (stall),
    .flush         (flush),
    .regWrite      (regWrite),
    .writeReg      (writeReg),
    .writeData     (writeData),
    .fwd_valid     (fwd_valid),
    .fwd_reg       (fwd_reg),
    .fwd_data      (fwd_data),
    .load_fault    (load_fault),
    .fault_addr    (fault_addr),
    .retire_count  (retire_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Load result from the architectural rules: big-endian lanes, LB/LH signed.
  function automatic logic [31:0] ref_result(input int lt, input logic [31:0] addr,
                                             input logic [31:0] mem, input logic m2r);
    int off;
    int unsigned b, h;
    off = int'(addr % 4);
    b   = (mem >> (8 * (3 - off))) % 256;
    h   = (off >= 2) ? (mem % 65536) : (mem / 65536);
    if (!m2r || lt > 4) return addr;
    case (lt)
      0:       return mem;
      1:       return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      2:       return 32'(h);
      3:       return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      default: return 32'(b);
    endcase
  endfunction

  function automatic logic ref_misaligned(input int lt, input logic [31:0] addr, input logic m2r);
    int off;
    off = int'(addr % 4);
    if (!m2r) return 1'b0;
    if (lt == 0) return off != 0;
    if (lt == 1 || lt == 2) return (off % 2) == 1;
    return 1'b0;
  endfunction

  task automatic check_outputs();
    check_val("regWrite",   32'(regWrite),   32'(m_valid && m_first && m_wr));
    check_val("fwd_valid",  32'(fwd_valid),  32'(m_valid && m_wr));
    check_val("load_fault", 32'(load_fault), 32'(m_valid && m_first && m_fault));
    check_val("writeReg",   32'(writeReg),   32'(m_dest));
    check_val("writeData",  writeData,       m_data);
    check_val("fwd_reg",    32'(fwd_reg),    32'(m_dest));
    check_val("fwd_data",   fwd_data,        m_data);
    check_val("fault_addr", fault_addr,      m_faddr);
    check_val("retire",     retire_count,    m_retire);
  endtask

  // One clock: drive at negedge, model advances at posedge, compare at next negedge.
  task automatic step(input logic rst, input logic v, input logic st, input logic fl,
                      input logic rw, input logic m2r, input logic [2:0] lt,
                      input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] dst);
    logic flt;
    reset = rst; in_valid = v; stall = st; flush = fl; in_reg_write = rw;
    in_mem_to_reg = m2r; in_load_type = lt; in_alu_result = alu; in_mem_data = mem; in_dest = dst;
    #1;
    check_val("in_ready", 32'(in_ready), 32'(!st && !rst));
    @(posedge clock);
    if (rst) begin
      m_valid = 0; m_first = 0; m_wr = 0; m_fault = 0;
      m_dest = '0; m_data = '0; m_faddr = '0; m_retire = '0;
    end else if (fl) begin
      m_valid = 0; m_first = 0;
    end else if (st) begin
      m_first = 0;
    end else if (v) begin
      flt      = ref_misaligned(int'(lt), alu, m2r);
      m_valid  = 1; m_first = 1;
      m_dest   = dst;
      m_data   = ref_result(int'(lt), alu, mem, m2r);
      m_fault  = flt;
      m_wr     = rw && dst != 5'd0 && !flt;
      m_retire = m_retire + 1;
      if (flt) m_faddr = alu;
    end else begin
      m_valid = 0; m_first = 0;
    end
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 3'd5, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    reset = 1; in_valid = 0; stall = 0; flush = 0; in_reg_write = 0; in_mem_to_reg = 0;
    in_load_type = 3'd5; in_alu_result = '0; in_mem_data = '0; in_dest = '0;
    @(negedge clock);
    step(1, 0, 0, 0, 0, 0, 3'd5, 32'h0, 32'h0, 5'd0);
    step(1, 1, 0, 0, 1, 0, 3'd5, 32'h1, 32'h0, 5'd3);
    check_val("rst_retire", retire_count, 32'd0);
    check_val("rst_wr", 32'(regWrite), 32'd0);

    // ALU op
    step(0, 1, 0, 0, 1, 0, 3'd5, 32'h12345678, 32'hAAAAAAAA, 5'd8);
    check_val("alu_wd", writeData, 32'h12345678);
    check_val("alu_wr", 32'(regWrite), 32'd1);
    check_val("alu_ret", retire_count, 32'd1);

    // Sub-word loads
    step(0, 1, 0, 0, 1, 1, 3'd3, 32'h1001, 32'h11F02233, 5'd4);
    check_val("lb", writeData, 32'hFFFFFFF0);
    step(0, 1, 0, 0, 1, 1, 3'd4, 32'h1001, 32'h11F02233, 5'd4);
    check_val("lbu", writeData, 32'h000000F0);
    step(0, 1, 0, 0, 1, 1, 3'd2, 32'h1002, 32'h1122ABCD, 5'd5);
    check_val("lhu", writeData, 32'h0000ABCD);
    step(0, 1, 0, 0, 1, 1, 3'd1, 32'h1000, 32'h8001ABCD, 5'd5);
    check_val("lh", writeData, 32'hFFFF8001);

    // Misaligned LW
    step(0, 1, 0, 0, 1, 1, 3'd0, 32'h2002, 32'h01020304, 5'd6);
    check_val("mis_fault", 32'(load_fault), 32'd1);
    check_val("mis_addr", fault_addr, 32'h00002002);
    check_val("mis_wr", 32'(regWrite), 32'd0);
    idle();
    check_val("mis_pulse", 32'(load_fault), 32'd0);
    check_val("mis_sticky", fault_addr, 32'h00002002);

    // $zero destination
    step(0, 1, 0, 0, 1, 0, 3'd5, 32'hDEADBEEF, 32'h0, 5'd0);
    check_val("zero_wr", 32'(regWrite), 32'd0);
    check_val("zero_fwd", 32'(fwd_valid), 32'd0);

    // Capture then stall for 3 cycles
    step(0, 1, 0, 0, 1, 0, 3'd5, 32'h00000099, 32'h0, 5'd9);
    check_val("stall_wr0", 32'(regWrite), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 1, 0, 3'd5, 32'h55555555, 32'h0, 5'd10);
      check_val("stall_wr", 32'(regWrite), 32'd0);
      check_val("stall_fwd", 32'(fwd_valid), 32'd1);
    end

    // Flush with in_valid high
    step(0, 1, 0, 1, 1, 0, 3'd5, 32'h77777777, 32'h0, 5'd11);
    check_val("flush_fwd", 32'(fwd_valid), 32'd0);

    // Reset while stalled
    step(0, 1, 0, 0, 1, 0, 3'd5, 32'h31313131, 32'h0, 5'd12);
    step(0, 1, 1, 0, 1, 0, 3'd5, 32'h0, 32'h0, 5'd12);
    step(1, 1, 1, 0, 1, 0, 3'd5, 32'h0, 32'h0, 5'd12);
    check_val("rst_mid_fwd", 32'(fwd_valid), 32'd0);
    check_val("rst_mid_wd", writeData, 32'd0);

    // Retire counter wrap
    force dut.retire_count_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_count_q;
    m_retire = 32'hFFFFFFFF;
    #1;
    check_val("preset", retire_count, 32'hFFFFFFFF);
    step(0, 1, 0, 0, 1, 0, 3'd5, 32'h1, 32'h0, 5'd1);
    check_val("wrap", retire_count, 32'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] alu;
      logic [4:0]  dst;
      alu = $urandom;
      dst = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 75,
           $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 85, 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), alu, $urandom, dst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
